// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the registered N-to-2^N decoder.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned ONEHOT_MAX_W = 64;

    // Active-high one-hot; the caller applies output polarity and narrows to its width.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx,
                                                       input int unsigned width);
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        if (idx < width && idx < ONEHOT_MAX_W) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_div.sv
// Scan-rate divider: counts run cycles and raises step on the last one of each period.
module decoder_scan_div #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic step
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        step  = run && (div_q == DIV_LAST);
        div_d = div_q + DIV_W'(1);
        if (!run || step) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/decoder_n2n_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with DIRECT decode and timed SCAN walk.
module decoder_n2n_seq
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter int unsigned SCAN_DIV   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic                    y_valid,
    output logic [SEL_W-1:0]        cur_idx,
    output logic                    scan_wrap
);

    localparam int unsigned OUT_W = 1 << SEL_W;
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

    logic [SEL_W-1:0] cur_idx_q, cur_idx_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             scan_wrap_q, scan_wrap_d;

    logic             scan_mode;
    logic             step;
    logic             vld;
    logic [SEL_W-1:0] next_idx;
    logic [OUT_W-1:0] y_oh;

    assign scan_mode = (mode == MODE_SCAN);

    decoder_scan_div #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_div (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (enable && scan_mode),
        .step  (step)
    );

    always_comb begin
        next_idx = cur_idx_q;
        if (scan_mode) begin
            // Power-of-two output count makes the natural overflow the scan wrap.
            if (step) begin
                next_idx = cur_idx_q + SEL_W'(1);
            end
        end else if (sel_valid) begin
            next_idx = sel;
        end

        vld  = scan_mode || sel_valid || y_valid_q;
        y_oh = OUT_W'(onehot(32'(next_idx), OUT_W));

        cur_idx_d   = cur_idx_q;
        y_valid_d   = 1'b0;
        y_d         = INACTIVE;
        scan_wrap_d = 1'b0;
        if (enable) begin
            cur_idx_d   = next_idx;
            y_valid_d   = vld;
            y_d         = vld ? (y_oh ^ INACTIVE) : INACTIVE;
            scan_wrap_d = step && (cur_idx_q == IDX_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_idx_q   <= '0;
            y_q         <= INACTIVE;
            y_valid_q   <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else begin
            cur_idx_q   <= cur_idx_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign cur_idx   = cur_idx_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_decoder_n2n_seq.sv
// Bench for decoder_n2n_seq: three instances checked against a cycle-level reference model.
module tb_decoder_n2n_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic       sel_valid;
    logic [1:0] sel2;
    logic [2:0] sel3;

    logic [3:0] ya, yb;
    logic [7:0] yc;
    logic       yva, yvb, yvc;
    logic [1:0] ia, ib;
    logic [2:0] ic;
    logic       wa, wb, wc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decoder_n2n_seq #(.SEL_W(2), .ACTIVE_LOW(1'b0), .SCAN_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel_valid(sel_valid),
        .sel(sel2), .y(ya), .y_valid(yva), .cur_idx(ia), .scan_wrap(wa)
    );

    decoder_n2n_seq #(.SEL_W(2), .ACTIVE_LOW(1'b1), .SCAN_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel_valid(sel_valid),
        .sel(sel2), .y(yb), .y_valid(yvb), .cur_idx(ib), .scan_wrap(wb)
    );

    decoder_n2n_seq #(.SEL_W(3), .ACTIVE_LOW(1'b0), .SCAN_DIV(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel_valid(sel_valid),
        .sel(sel3), .y(yc), .y_valid(yvc), .cur_idx(ic), .scan_wrap(wc)
    );

    // Reference model: per instance, index, valid, wrap and count of scan cycles run so far.
    int unsigned m_div [3]  = '{4, 1, 3};
    int unsigned m_outw[3]  = '{4, 4, 8};
    bit          m_al  [3]  = '{1'b0, 1'b1, 1'b0};
    int unsigned m_idx [3];
    bit          m_vld [3];
    bit          m_wrap[3];
    int unsigned m_cnt [3];

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int unsigned s;
            s = (k == 2) ? 32'(sel3) : 32'(sel2);
            if (!rst_n) begin
                m_idx[k] = 0; m_vld[k] = 0; m_wrap[k] = 0; m_cnt[k] = 0;
            end else if (!enable) begin
                m_vld[k] = 0; m_wrap[k] = 0; m_cnt[k] = 0;
            end else if (mode) begin
                m_vld[k]  = 1;
                m_wrap[k] = 0;
                if (m_cnt[k] + 1 == m_div[k]) begin
                    m_wrap[k] = (m_idx[k] == m_outw[k] - 1);
                    m_idx[k]  = (m_idx[k] + 1) % m_outw[k];
                    m_cnt[k]  = 0;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end else begin
                m_cnt[k]  = 0;
                m_wrap[k] = 0;
                if (sel_valid) m_idx[k] = s;
                m_vld[k] = m_vld[k] || sel_valid;
            end
        end
    endtask

    function automatic logic [31:0] exp_y(int k);
        logic [31:0] v;
        logic [31:0] mask;
        mask = (32'd1 << m_outw[k]) - 32'd1;
        v = m_vld[k] ? (32'd1 << m_idx[k]) : 32'd0;
        if (m_al[k]) v = ~v & mask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("a_y", 32'(ya), exp_y(0));   chk("a_yv", 32'(yva), 32'(m_vld[0]));
        chk("a_idx", 32'(ia), m_idx[0]); chk("a_wrap", 32'(wa), 32'(m_wrap[0]));
        chk("b_y", 32'(yb), exp_y(1));   chk("b_yv", 32'(yvb), 32'(m_vld[1]));
        chk("b_idx", 32'(ib), m_idx[1]); chk("b_wrap", 32'(wb), 32'(m_wrap[1]));
        chk("c_y", 32'(yc), exp_y(2));   chk("c_yv", 32'(yvc), 32'(m_vld[2]));
        chk("c_idx", 32'(ic), m_idx[2]); chk("c_wrap", 32'(wc), 32'(m_wrap[2]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       en;
        logic       md;
        logic       sv;
        logic [1:0] sel;
        logic [3:0] y;
        logic       yv;
        logic [1:0] idx;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic en, logic md, logic sv, logic [1:0] sel,
                                logic [3:0] y, logic yv, logic [1:0] idx, logic wrap);
        vec_t v;
        v.en = en; v.md = md; v.sv = sv; v.sel = sel;
        v.y = y; v.yv = yv; v.idx = idx; v.wrap = wrap;
        vecs.push_back(v);
    endfunction

    initial begin
        bit found;

        // Directed expectations for the SEL_W=2, SCAN_DIV=4 instance.
        add(1, 0, 1, 2, 4'b0100, 1, 2, 0);
        add(1, 0, 0, 3, 4'b0100, 1, 2, 0);
        add(0, 0, 0, 0, 4'b0000, 0, 2, 0);
        add(1, 0, 1, 0, 4'b0001, 1, 0, 0);
        for (int r = 0; r < 3; r++) add(1, 1, 0, 3, 4'b0001, 1, 0, 0);
        add(1, 1, 0, 3, 4'b0010, 1, 1, 0);
        for (int r = 0; r < 3; r++) add(1, 1, 1, 0, 4'b0010, 1, 1, 0);
        add(1, 1, 1, 0, 4'b0100, 1, 2, 0);
        for (int r = 0; r < 3; r++) add(1, 1, 0, 1, 4'b0100, 1, 2, 0);
        add(1, 1, 0, 1, 4'b1000, 1, 3, 0);
        for (int r = 0; r < 3; r++) add(1, 1, 0, 2, 4'b1000, 1, 3, 0);
        add(1, 1, 0, 2, 4'b0001, 1, 0, 1);
        add(1, 1, 0, 2, 4'b0001, 1, 0, 0);

        rst_n = 0; enable = 1; mode = 1; sel_valid = 1; sel2 = 3; sel3 = 5;
        tick();
        tick();
        chk("rst_y", 32'(ya), 32'h0);
        chk("rst_yv", 32'(yva), 32'h0);
        chk("rst_idx", 32'(ia), 32'h0);
        chk("rst_wrap", 32'(wa), 32'h0);
        chk("rst_y_al", 32'(yb), 32'hf);

        rst_n = 1;
        foreach (vecs[i]) begin
            enable = vecs[i].en; mode = vecs[i].md; sel_valid = vecs[i].sv;
            sel2 = vecs[i].sel; sel3 = 3'(vecs[i].sel);
            tick();
            chk($sformatf("vec%0d_y", i), 32'(ya), 32'(vecs[i].y));
            chk($sformatf("vec%0d_yv", i), 32'(yva), 32'(vecs[i].yv));
            chk($sformatf("vec%0d_idx", i), 32'(ia), 32'(vecs[i].idx));
            chk($sformatf("vec%0d_wrap", i), 32'(wa), 32'(vecs[i].wrap));
        end

        // Scan to the cycle just before a wrap step, then reset over it.
        enable = 1; mode = 1; sel_valid = 0;
        found = 0;
        for (int n = 0; n < 64; n++) begin
            if (m_idx[0] == 3 && m_cnt[0] == 3) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("midscan_reached", 32'(found), 32'd1);
        rst_n = 0;
        tick();
        chk("midscan_rst_y", 32'(ya), 32'h0);
        chk("midscan_rst_idx", 32'(ia), 32'h0);
        chk("midscan_rst_wrap", 32'(wa), 32'h0);

        rst_n = 1; enable = 1; mode = 0; sel_valid = 1; sel2 = 1; sel3 = 7;
        tick();
        chk("al_sel1_y", 32'(yb), 32'hd);
        chk("w3_sel7_y", 32'(yc), 32'h80);

        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel_valid = $urandom_range(0, 1) == 1;
            sel2      = 2'($urandom);
            sel3      = 3'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
